matrix_stream_reader: RTL and testbench

- Read-side counterpart of the matrix storage write protocol: fetches one stored matrix (metadata plus elements) through the storage manager's synchronous read port.
- Emits the elements as a row-major valid/ready stream with row/col tags and a last flag.
- Consumers: UART/display dump path and future operators that need a flow-controlled source instead of raw BRAM addressing.
- Owns the shared read port only while `read_active` is high; the external mux selects on that signal.

---
 rtl/matrix_storage_layout_pkg.sv | 24 ++
 rtl/stream_skid_fifo.sv | 45 ++++
 rtl/matrix_stream_reader.sv | 160 ++++++++++++++++
 tb/tb_matrix_stream_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_storage_layout_pkg.sv
// rtl/matrix_storage_layout_pkg.sv - matrix slot layout shared by the storage writer and reader
package matrix_storage_layout_pkg;

    localparam int META_WORDS          = 3;
    localparam int META_ROWS_OFF       = 0;
    localparam int META_NAME_OFF       = 1;
    localparam int ROWS_LSB            = 0;
    localparam int COLS_LSB            = 8;
    localparam int NAME_BYTES          = 8;
    localparam int NAME_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_META,
        RD_CHECK,
        RD_STREAM,
        RD_FINISH
    } reader_state_t;

    function automatic int unsigned slot_base(input logic [2:0] id, input int unsigned block_size);
        return block_size * {29'd0, id};
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - two-entry FIFO decoupling storage reads from the output stream
module stream_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Push and pop together on a full FIFO is legal: the popped slot is the one overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/matrix_stream_reader.sv
// rtl/matrix_stream_reader.sv - fetches one stored matrix and emits it as a row-major tagged stream
module matrix_stream_reader
    import matrix_storage_layout_pkg::*;
#(
    parameter int BLOCK_SIZE = 1152,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            matrix_id,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            rows,
    output logic [7:0]            cols,
    output logic [7:0]            matrix_name [NAME_BYTES],
    output logic                  meta_valid,
    output logic                  read_active,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col
);
    reader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, addr_hold_q;
    logic [1:0]            meta_cnt_q, cap_idx_q, fifo_count;
    logic                  cap_valid_q, inflight_q, err_q, meta_valid_q;
    logic [10:0]           total_q, issued_q, popped_q;
    logic [7:0]            rows_q, cols_q, row_q, col_q;
    logic [7:0]            name_q [NAME_BYTES];
    logic                  issue, pop, dims_bad;

    stream_skid_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bram_data_out),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    // A pop this cycle frees a slot in time for the word returning next cycle.
    assign issue     = (state_q == RD_STREAM) && (issued_q < total_q) &&
                       (((fifo_count + {1'b0, inflight_q}) < 2'd2) || pop);
    assign dims_bad  = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                       (rows_q > 8'(MAX_DIM)) || (cols_q > 8'(MAX_DIM));

    assign busy        = (state_q == RD_META) || (state_q == RD_CHECK) || (state_q == RD_STREAM);
    assign done        = (state_q == RD_FINISH);
    assign error       = done && err_q;
    assign read_active = (state_q == RD_META) || (state_q == RD_STREAM);
    assign rows        = rows_q;
    assign cols        = cols_q;
    assign matrix_name = name_q;
    assign meta_valid  = meta_valid_q;
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign out_last    = out_valid && (popped_q == total_q - 11'd1);

    always_comb begin
        read_addr = addr_hold_q;
        if (state_q == RD_META) begin
            read_addr = base_q + ADDR_WIDTH'(meta_cnt_q);
        end else if (issue) begin
            read_addr = base_q + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(issued_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   if (start) state_d = RD_META;
            RD_META:   if (meta_cnt_q == 2'd2) state_d = RD_CHECK;
            RD_CHECK:  state_d = dims_bad ? RD_FINISH : RD_STREAM;
            RD_STREAM: if (pop && (popped_q == total_q - 11'd1)) state_d = RD_FINISH;
            RD_FINISH: state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            base_q       <= '0;
            addr_hold_q  <= '0;
            meta_cnt_q   <= 2'd0;
            cap_idx_q    <= 2'd0;
            cap_valid_q  <= 1'b0;
            inflight_q   <= 1'b0;
            err_q        <= 1'b0;
            meta_valid_q <= 1'b0;
            total_q      <= 11'd0;
            issued_q     <= 11'd0;
            popped_q     <= 11'd0;
            rows_q       <= 8'd0;
            cols_q       <= 8'd0;
            row_q        <= 8'd0;
            col_q        <= 8'd0;
            for (int k = 0; k < NAME_BYTES; k++) name_q[k] <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_hold_q <= read_addr;
            inflight_q  <= issue;
            // Metadata word issued in META cycle n is on bram_data_out the following cycle.
            cap_valid_q <= (state_q == RD_META);
            cap_idx_q   <= meta_cnt_q;
            if ((state_q == RD_IDLE) && start) begin
                base_q       <= ADDR_WIDTH'(slot_base(matrix_id, BLOCK_SIZE));
                meta_cnt_q   <= 2'd0;
                issued_q     <= 11'd0;
                popped_q     <= 11'd0;
                row_q        <= 8'd0;
                col_q        <= 8'd0;
                err_q        <= 1'b0;
                meta_valid_q <= 1'b0;
            end
            if (state_q == RD_META) meta_cnt_q <= meta_cnt_q + 2'd1;
            if (cap_valid_q) begin
                if (cap_idx_q == 2'(META_ROWS_OFF)) begin
                    rows_q <= bram_data_out[ROWS_LSB +: 8];
                    cols_q <= bram_data_out[COLS_LSB +: 8];
                end else if (cap_idx_q == 2'(META_NAME_OFF)) begin
                    for (int b = 0; b < NAME_BYTES_PER_WORD; b++) name_q[b] <= bram_data_out[8*b +: 8];
                end else begin
                    for (int b = 0; b < NAME_BYTES_PER_WORD; b++)
                        name_q[b + NAME_BYTES_PER_WORD] <= bram_data_out[8*b +: 8];
                end
            end
            if (state_q == RD_CHECK) begin
                if (dims_bad) begin
                    err_q <= 1'b1;
                end else begin
                    meta_valid_q <= 1'b1;
                    total_q      <= 11'(rows_q) * 11'(cols_q);
                end
            end
            if (issue) issued_q <= issued_q + 11'd1;
            if (pop) begin
                popped_q <= popped_q + 11'd1;
                if (col_q == cols_q - 8'd1) begin
                    col_q <= 8'd0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// tb/tb_matrix_stream_reader.sv - scoreboard bench for matrix_stream_reader
module tb_matrix_stream_reader;
    localparam int BLOCK_SIZE = 1152;
    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_DIM    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n, start, out_ready;
    logic [2:0]            matrix_id;
    logic                  busy, done, error, meta_valid, read_active;
    logic [7:0]            rows, cols, out_row, out_col;
    logic [7:0]            matrix_name [8];
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] bram_data_out, out_data;
    logic                  out_valid, out_last;

    always #5 clk = ~clk;

    matrix_stream_reader #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .matrix_id     (matrix_id),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .rows          (rows),
        .cols          (cols),
        .matrix_name   (matrix_name),
        .meta_valid    (meta_valid),
        .read_active   (read_active),
        .read_addr     (read_addr),
        .bram_data_out (bram_data_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_row       (out_row),
        .out_col       (out_col)
    );

    logic [31:0] mem [0:16383];
    always @(posedge clk) bram_data_out <= mem[read_addr];

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_err_q[$];
    int    total = 0, bad = 0, cyc = 0;
    int    rd_beats = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
    bit    rdy_rand_mode = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat, mon_cur, mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want nothing", nm, act);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every accepted beat and every done pulse.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_cur = {out_data, out_row, out_col, out_last};
            if (prev_stall) check("stall_hold", 64'({out_valid, mon_cur}), 64'({1'b1, prev_beat}));
            if (out_valid && exp_q.size() == 0) begin
                flag("unexpected_valid", 64'(mon_cur));
            end else if (out_valid && out_ready) begin
                mon_exp = exp_q.pop_front();
                check("beat", 64'(mon_cur), 64'(mon_exp));
                if (rd_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                rd_beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = mon_cur;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_err_q.size() == 0) flag("unexpected_done", 64'(error));
                else check("done_error", 64'(error), 64'(exp_err_q.pop_front()));
            end
        end
    end

    task automatic write_slot(input int id, input int r, input int c, input logic [7:0] n0,
                              input bit nincr, input int vmode);
        int base;
        base = id * BLOCK_SIZE;
        mem[base] = {16'h0, 8'(c), 8'(r)};
        for (int k = 0; k < 8; k++) mem[base + 1 + k/4][8*(k%4) +: 8] = n0 + (nincr ? 8'(k) : 8'd0);
        if (r >= 1 && c >= 1 && r <= MAX_DIM && c <= MAX_DIM)
            for (int i = 0; i < r*c; i++)
                mem[base + 3 + i] = (vmode == 0) ? 32'(i + 1) : (vmode == 1) ? 32'(i) : $urandom;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ctl"}, 64'({busy, done, error, meta_valid, read_active, out_valid, out_last}), 64'd0);
        check({nm, "_dims"}, 64'({rows, cols, out_row, out_col}), 64'd0);
        check({nm, "_data"}, 64'(out_data), 64'd0);
        check({nm, "_addr"}, 64'(read_addr), 64'd0);
    endtask

    task automatic run_read(input int id, input bit rnd, input bit repulse);
        int base, r, c, n, lat, w, d0;
        bit err;
        base = id * BLOCK_SIZE;
        r    = int'(mem[base][7:0]);
        c    = int'(mem[base][15:8]);
        err  = (r == 0) || (c == 0) || (r > MAX_DIM) || (c > MAX_DIM);
        n    = err ? 0 : r * c;
        for (int i = 0; i < n; i++)
            exp_q.push_back({mem[base + 3 + i], 8'(i / c), 8'(i % c), (i == n - 1)});
        exp_err_q.push_back(err);
        rdy_rand_mode = rnd;
        rd_beats      = 0;
        d0            = done_cnt;
        @(posedge clk); #1;
        start     = 1'b1;
        matrix_id = 3'(id);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        if (!err) begin
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("first_valid_latency", 64'(lat), 64'd6);
        end
        if (repulse) begin
            start     = 1'b1;
            matrix_id = 3'(id + 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 5000) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 5000) begin
            flag("done_timeout", 64'(w));
        end else begin
            check("busy_at_done", 64'(busy), 64'd0);
            check("meta_valid", 64'(meta_valid), 64'(!err));
            if (!err) begin
                check("rows", 64'(rows), 64'(r));
                check("cols", 64'(cols), 64'(c));
                for (int k = 0; k < 8; k++)
                    check("name_byte", 64'(matrix_name[k]), 64'(mem[base + 1 + k/4][8*(k%4) +: 8]));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("beat_count", 64'(rd_beats), 64'(n));
        if (!err && !rnd) check("contiguous_beats", 64'(last_cyc - first_cyc), 64'(n - 1));
        if (!err) check("done_after_last", 64'(done_cyc - last_cyc), 64'd1);
    endtask

    task automatic reset_abort();
        int base, n, w;
        base = 3 * BLOCK_SIZE;
        n    = 9;
        for (int i = 0; i < n; i++) exp_q.push_back({mem[base + 3 + i], 8'(i / 3), 8'(i % 3), (i == n - 1)});
        exp_err_q.push_back(1'b0);
        rdy_rand_mode = 1'b0;
        rd_beats      = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        matrix_id = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (rd_beats < 2 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) flag("abort_wait_timeout", 64'(rd_beats));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_err_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        matrix_id = 3'd0;
        out_ready = 1'b1;
        for (int a = 0; a < 16384; a++) mem[a] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        write_slot(1, 2, 2, 8'h41, 1'b0, 0);
        write_slot(3, 3, 3, 8'h50, 1'b1, 0);
        write_slot(0, 32, 32, 8'h30, 1'b1, 1);

        run_read(1, 1'b0, 1'b0);
        run_read(3, 1'b1, 1'b0);
        run_read(5, 1'b0, 1'b0);
        run_read(1, 1'b0, 1'b1);
        reset_abort();
        run_read(1, 1'b0, 1'b0);
        run_read(0, 1'b0, 1'b0);
        check("last_issued_addr", 64'(read_addr), 64'(3 + 1023));

        write_slot(2, 1, 1, 8'h61, 1'b1, 2);
        run_read(2, 1'b0, 1'b0);
        write_slot(4, 1, 32, 8'h10, 1'b1, 2);
        run_read(4, 1'b1, 1'b0);
        write_slot(6, 33, 1, 8'h20, 1'b1, 2);
        run_read(6, 1'b0, 1'b0);
        write_slot(7, 5, 0, 8'h70, 1'b1, 2);
        run_read(7, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int id, r, c;
            id = (t % 4 == 0) ? 2 : (t % 4 == 1) ? 4 : (t % 4 == 2) ? 6 : 7;
            if ($urandom_range(0, 4) == 0) begin
                r = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
                c = int'($urandom_range(0, 40));
            end else begin
                r = int'($urandom_range(1, 6));
                c = int'($urandom_range(1, 6));
            end
            write_slot(id, r, c, 8'($urandom), 1'b1, 2);
            run_read(id, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
